// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks a register-initialisation table and issues one I2C write
// per entry. Handles END and DELAY markers, retries a NACKed or timed-out
// transfer, latches restart requests, and reports the first failing entry.
module i2c_init_seq #(
    parameter int ADDR_W      = 8,
    parameter int RETRIES     = 3,
    parameter int DELAY_CYC   = 50_000,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              restart,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic [23:0]       i2c_data,
    output logic              i2c_start,
    input  logic              i2c_end,
    input  logic              i2c_ack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_index
);

    localparam int RTY_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    localparam int TO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int DLY_W = $clog2(255 * DELAY_CYC + 1);

    localparam logic [7:0] DEV_END   = 8'hFF;
    localparam logic [7:0] DEV_DELAY = 8'hFE;

    typedef enum logic [2:0] {
        FETCH, DECODE, START, WAIT_LO, WAIT_HI, DELAY, DONE, ERROR
    } state_t;

    state_t             state, state_d;
    logic [RTY_W-1:0]   retry_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [DLY_W-1:0]   dly_cnt;
    logic               restart_pend;

    logic [7:0]         dev;
    logic               restart_any;
    logic               at_last;
    logic               to_hit;
    logic               can_retry;
    logic               step;       // current entry finished, move to the next one
    logic               nack;       // transfer failed (NACK or timeout)
    logic               apply_rst;  // restart takes effect this cycle

    assign dev         = tbl_data[23:16];
    assign restart_any = restart | restart_pend;
    assign at_last     = (tbl_addr == {ADDR_W{1'b1}});
    assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign can_retry   = (32'(retry_cnt) < 32'(RETRIES));

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block evaluation order.
        if (!iRST_N) state <= FETCH;
        else         state <= state_d;
    end

    // Next-state logic plus the per-cycle step / nack / restart decisions
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise the
        // paths that do not assign it would infer a latch.
        state_d   = state;
        step      = 1'b0;
        nack      = 1'b0;
        apply_rst = 1'b0;
        case (state)
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (dev == DEV_END) begin
                    state_d   = restart_any ? FETCH : DONE;
                    apply_rst = restart_any;
                end else if (dev == DEV_DELAY) begin
                    if (tbl_data[7:0] == 8'd0) step = 1'b1;
                    else                       state_d = DELAY;
                end else begin
                    state_d = START;
                end
            end
            START:   state_d = WAIT_LO;
            WAIT_LO: begin
                if (to_hit)        nack    = 1'b1;
                else if (!i2c_end) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (i2c_end) begin
                    if (i2c_ack) nack = 1'b1;
                    else         step = 1'b1;
                end else if (to_hit) begin
                    nack = 1'b1;
                end
            end
            DELAY:   if (dly_cnt == DLY_W'(1)) step = 1'b1;
            DONE, ERROR: begin
                if (restart_any) begin
                    state_d   = FETCH;
                    apply_rst = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
        if (nack) state_d = can_retry ? START : ERROR;
        // A pending restart replaces the next fetch (and also overrides table end)
        if (step) begin
            apply_rst = restart_any;
            state_d   = (restart_any || !at_last) ? FETCH : DONE;
        end
    end

    // Datapath: table index, transfer word, counters, restart latch, status flags
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tbl_addr     <= '0;
            i2c_data     <= '0;
            retry_cnt    <= '0;
            to_cnt       <= '0;
            dly_cnt      <= '0;
            restart_pend <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_index    <= '0;
        end else begin
            if (apply_rst)    restart_pend <= 1'b0;
            else if (restart) restart_pend <= 1'b1;

            if (apply_rst)                tbl_addr <= '0;
            else if (step && !at_last)    tbl_addr <= tbl_addr + ADDR_W'(1);

            if (state == DECODE && state_d == START) begin
                i2c_data  <= tbl_data;
                retry_cnt <= '0;
            end else if (nack && can_retry) begin
                retry_cnt <= retry_cnt + RTY_W'(1);
            end

            if (state == START)                             to_cnt <= '0;
            else if (state == WAIT_LO || state == WAIT_HI)  to_cnt <= to_cnt + TO_W'(1);

            if (state == DECODE && state_d == DELAY)
                dly_cnt <= DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_CYC);
            else if (state == DELAY)
                dly_cnt <= dly_cnt - DLY_W'(1);

            // DONE and ERROR are only left through a restart, so these stay sticky
            done      <= (state_d == DONE);
            error     <= (state_d == ERROR);
            err_index <= (state_d == ERROR) ? tbl_addr : '0;
        end
    end

    // Outputs decoded from the state so a reset drops i2c_start immediately
    always_comb begin
        i2c_start = (state == START) || (state == WAIT_LO);
        busy      = (state != DONE) && (state != ERROR);
    end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: a synchronous ROM model and a small I2C
// master model drive the main instance; a second instance with RETRIES=0 and
// an unresponsive master exercises the timeout path.
module tb_i2c_init_seq;

    localparam int AW = 3;

    logic clk;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // main instance signals
    logic          rst_n, restart;
    logic [AW-1:0] tbl_addr, err_index;
    logic [23:0]   tbl_data, i2c_data;
    logic          i2c_start, i2c_end, i2c_ack, busy, done, error;

    // timeout instance signals
    logic          rst1_n, restart1;
    logic [AW-1:0] tbl_addr1, err_index1;
    logic [23:0]   tbl_data1, i2c_data1;
    logic          i2c_start1, i2c_end1, i2c_ack1, busy1, done1, error1;

    logic [23:0]   rom [0:7];
    logic [23:0]   log_data[$];
    int            log_cyc[$];
    logic [23:0]   nack_data;
    int            nack_left;

    i2c_init_seq #(.ADDR_W(AW), .RETRIES(3), .DELAY_CYC(10), .TIMEOUT_CYC(100)) dut (
        .iCLK(clk), .iRST_N(rst_n), .restart(restart), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .i2c_data(i2c_data), .i2c_start(i2c_start),
        .i2c_end(i2c_end), .i2c_ack(i2c_ack), .busy(busy), .done(done),
        .error(error), .err_index(err_index)
    );

    i2c_init_seq #(.ADDR_W(AW), .RETRIES(0), .DELAY_CYC(10), .TIMEOUT_CYC(100)) dut1 (
        .iCLK(clk), .iRST_N(rst1_n), .restart(restart1), .tbl_addr(tbl_addr1),
        .tbl_data(tbl_data1), .i2c_data(i2c_data1), .i2c_start(i2c_start1),
        .i2c_end(i2c_end1), .i2c_ack(i2c_ack1), .busy(busy1), .done(done1),
        .error(error1), .err_index(err_index1)
    );

    // Clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for timing measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous table ROM: data valid one cycle after the address
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Wait n falling edges, flagging an abort if reset is seen
    task automatic master_wait(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst_n) begin ab = 1'b1; break; end
        end
    endtask

    // I2C master model: 2 cycles to go busy, 3 cycles busy, then ack/nack
    initial begin : master
        bit ab;
        i2c_end = 1'b1;
        i2c_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && i2c_start && i2c_end) begin
                log_data.push_back(i2c_data);
                log_cyc.push_back(cyc);
                master_wait(2, ab);
                if (!ab) begin
                    i2c_end = 1'b0;
                    master_wait(3, ab);
                end
                i2c_ack = 1'b0;
                if (!ab && i2c_data == nack_data && nack_left > 0) begin
                    i2c_ack   = 1'b1;
                    nack_left = nack_left - 1;
                end
                i2c_end = 1'b1;
            end
        end
    end

    // Safety net in case some wait is not bounded as intended
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic fill_rom(input logic [23:0] v);
        for (int i = 0; i < 8; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        restart   = 1'b0;
        nack_left = 0;
        nack_data = '0;
        repeat (3) @(negedge clk);
        log_data.delete();
        log_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        fill_rom(24'hFF_00_00);
        repeat (2) @(negedge clk);
        n_cmp++; if (i2c_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", i2c_start); end
        n_cmp++; if (tbl_addr !== 3'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", tbl_addr); end
        n_cmp++; if (i2c_data !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h want 000000", i2c_data); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (err_index !== 3'd0) begin n_bad++; $display("FAIL reset_err_index: got %0d want 0", err_index); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        log_data.delete();
        log_cyc.delete();
        rst_n = 1'b1;
        wait_idle(20, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL empty_table_idle: got %b want 1", ok); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_table_done: got %b want 1", done); end
        n_cmp++; if (log_data.size() != 0) begin n_bad++; $display("FAIL empty_table_xfers: got %0d want 0", log_data.size()); end
    endtask

    task automatic test_basic();
        bit ok;
        fill_rom(24'hFF_00_00);
        rom[0] = 24'h72_98_03;
        rom[1] = 24'h72_41_10;
        do_reset();
        wait_idle(200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got %b want 1", ok); end
        n_cmp++; if (log_data.size() != 2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", log_data.size()); end
        n_cmp++; if (log_data[0] !== 24'h72_98_03) begin n_bad++; $display("FAIL basic_xfer0: got %h want 729803", log_data[0]); end
        n_cmp++; if (log_data[1] !== 24'h72_41_10) begin n_bad++; $display("FAIL basic_xfer1: got %h want 724110", log_data[1]); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", busy); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b want 0", error); end
    endtask

    task automatic test_retry();
        bit ok;
        fill_rom(24'hFF_00_00);
        rom[0] = 24'h72_98_03;
        rom[1] = 24'h72_41_10;
        do_reset();
        nack_data = 24'h72_41_10;
        nack_left = 3;
        wait_idle(300, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL retry_idle: got %b want 1", ok); end
        n_cmp++; if (log_data.size() != 5) begin n_bad++; $display("FAIL retry_count: got %0d want 5", log_data.size()); end
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if (log_data[i] !== 24'h72_41_10) begin n_bad++; $display("FAIL retry_xfer%0d: got %h want 724110", i, log_data[i]); end
        end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL retry_error: got %b want 0", error); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL retry_done: got %b want 1", done); end
    endtask

    task automatic test_error_and_restart();
        bit ok;
        int hits;
        int sz;
        for (int i = 0; i < 5; i++) rom[i] = 24'h72_10_00 | 24'(i);
        rom[5] = 24'h72_55_AA;
        rom[6] = 24'hFF_00_00;
        rom[7] = 24'hFF_00_00;
        do_reset();
        nack_data = 24'h72_55_AA;
        nack_left = 1000;
        wait_idle(500, ok);
        hits = 0;
        foreach (log_data[i]) if (log_data[i] == 24'h72_55_AA) hits++;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL err_idle: got %b want 1", ok); end
        n_cmp++; if (hits != 4) begin n_bad++; $display("FAIL err_attempts: got %0d want 4", hits); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", error); end
        n_cmp++; if (err_index !== 3'd5) begin n_bad++; $display("FAIL err_index: got %0d want 5", err_index); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL err_done: got %b want 0", done); end
        sz = log_data.size();
        repeat (40) @(negedge clk);
        n_cmp++; if (log_data.size() != sz) begin n_bad++; $display("FAIL err_no_more_start: got %0d want %0d", log_data.size(), sz); end
        n_cmp++; if (i2c_start !== 1'b0) begin n_bad++; $display("FAIL err_start_low: got %b want 0", i2c_start); end
        // restart out of ERROR
        nack_left = 0;
        log_data.delete();
        log_cyc.delete();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_err_clear: got %b want 0", error); end
        n_cmp++; if (err_index !== 3'd0) begin n_bad++; $display("FAIL rst_err_index: got %0d want 0", err_index); end
        n_cmp++; if (tbl_addr !== 3'd0) begin n_bad++; $display("FAIL rst_err_addr: got %0d want 0", tbl_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_err_busy: got %b want 1", busy); end
        wait_idle(400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_err_idle: got %b want 1", ok); end
        n_cmp++; if (log_data.size() != 6) begin n_bad++; $display("FAIL rst_err_count: got %0d want 6", log_data.size()); end
        n_cmp++; if (log_data[0] !== 24'h72_10_00) begin n_bad++; $display("FAIL rst_err_first: got %h want 721000", log_data[0]); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rst_err_done: got %b want 1", done); end
    endtask

    // Run a four-entry table and return the start-to-start gap of the two transfers
    task automatic run_gap(input logic [23:0] e1, input logic [23:0] e2, output int gap, output bit ok);
        fill_rom(24'hFF_00_00);
        rom[0] = 24'h72_98_03;
        rom[1] = e1;
        rom[2] = e2;
        do_reset();
        wait_idle(300, ok);
        if (log_cyc.size() >= 2) gap = log_cyc[1] - log_cyc[0];
        else                     gap = -1000;
    endtask

    task automatic test_delay();
        int gap_a, gap_b, gap_c;
        bit ok;
        run_gap(24'h72_41_10, 24'hFF_00_00, gap_c, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL delay_plain_idle: got %b want 1", ok); end
        run_gap(24'hFE_00_00, 24'h72_41_10, gap_b, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL delay0_idle: got %b want 1", ok); end
        n_cmp++; if (gap_b - gap_c < 0 || gap_b - gap_c > 2) begin n_bad++; $display("FAIL delay0_extra: got %0d want 0..2", gap_b - gap_c); end
        run_gap(24'hFE_00_02, 24'h72_41_10, gap_a, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL delay2_idle: got %b want 1", ok); end
        n_cmp++; if (gap_a - gap_b < 18 || gap_a - gap_b > 22) begin n_bad++; $display("FAIL delay2_cycles: got %0d want 18..22", gap_a - gap_b); end
        n_cmp++; if (log_data[1] !== 24'h72_41_10) begin n_bad++; $display("FAIL delay2_next: got %h want 724110", log_data[1]); end
    endtask

    task automatic test_restart_mid();
        bit ok;
        bit seen;
        for (int i = 0; i < 6; i++) rom[i] = 24'h72_30_00 | 24'(i);
        rom[6] = 24'hFF_00_00;
        rom[7] = 24'hFF_00_00;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tbl_addr == 3'd3 && !i2c_start && !i2c_end) begin seen = 1'b1; break; end
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL restart_mid_reach: got %b want 1", seen); end
        // two pulses inside the same transfer: the second must add nothing
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_idle(400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL restart_mid_idle: got %b want 1", ok); end
        n_cmp++; if (log_data.size() != 10) begin n_bad++; $display("FAIL restart_mid_count: got %0d want 10", log_data.size()); end
        n_cmp++; if (log_data[3] !== 24'h72_30_03) begin n_bad++; $display("FAIL restart_mid_idx3: got %h want 723003", log_data[3]); end
        n_cmp++; if (log_data[4] !== 24'h72_30_00) begin n_bad++; $display("FAIL restart_mid_replay0: got %h want 723000", log_data[4]); end
        n_cmp++; if (log_data[9] !== 24'h72_30_05) begin n_bad++; $display("FAIL restart_mid_last: got %h want 723005", log_data[9]); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_mid_done: got %b want 1", done); end
    endtask

    task automatic test_table_end();
        bit ok;
        for (int i = 0; i < 8; i++) rom[i] = 24'h72_20_00 | 24'(i);
        do_reset();
        wait_idle(400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL end_idle: got %b want 1", ok); end
        n_cmp++; if (log_data.size() != 8) begin n_bad++; $display("FAIL end_count: got %0d want 8", log_data.size()); end
        n_cmp++; if (log_data[7] !== 24'h72_20_07) begin n_bad++; $display("FAIL end_last: got %h want 722007", log_data[7]); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL end_done: got %b want 1", done); end
        repeat (20) @(negedge clk);
        n_cmp++; if (tbl_addr !== 3'd7) begin n_bad++; $display("FAIL end_no_wrap: got %0d want 7", tbl_addr); end
        n_cmp++; if (log_data.size() != 8) begin n_bad++; $display("FAIL end_no_more: got %0d want 8", log_data.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        fill_rom(24'hFF_00_00);
        rom[0] = 24'h72_98_03;
        rom[1] = 24'h72_41_10;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i2c_start && tbl_addr == 3'd1) begin seen = 1'b1; break; end
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach: got %b want 1", seen); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (i2c_start !== 1'b0) begin n_bad++; $display("FAIL rstmid_start_drop: got %b want 0", i2c_start); end
        n_cmp++; if (tbl_addr !== 3'd0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", tbl_addr); end
        repeat (3) @(negedge clk);
        log_data.delete();
        log_cyc.delete();
        rst_n = 1'b1;
        wait_idle(200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle: got %b want 1", ok); end
        n_cmp++; if (log_data.size() != 2) begin n_bad++; $display("FAIL rstmid_count: got %0d want 2", log_data.size()); end
        n_cmp++; if (log_data[0] !== 24'h72_98_03) begin n_bad++; $display("FAIL rstmid_first: got %h want 729803", log_data[0]); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rstmid_done: got %b want 1", done); end
    endtask

    task automatic test_timeout();
        int t0, t1;
        t0 = -1;
        t1 = -1;
        @(negedge clk);
        rst1_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i2c_start1) begin t0 = cyc; break; end
        end
        n_cmp++; if (t0 < 0) begin n_bad++; $display("FAIL timeout_start_seen: got none want a start"); end
        n_cmp++; if (i2c_data1 !== 24'h72_98_03) begin n_bad++; $display("FAIL timeout_data: got %h want 729803", i2c_data1); end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (error1) begin t1 = cyc; break; end
        end
        n_cmp++; if (error1 !== 1'b1) begin n_bad++; $display("FAIL timeout_error: got %b want 1", error1); end
        n_cmp++; if (t1 - t0 < 99 || t1 - t0 > 101) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 99..101", t1 - t0); end
        n_cmp++; if (err_index1 !== 3'd0) begin n_bad++; $display("FAIL timeout_err_index: got %0d want 0", err_index1); end
        n_cmp++; if (tbl_addr1 !== 3'd0) begin n_bad++; $display("FAIL timeout_addr: got %0d want 0", tbl_addr1); end
        n_cmp++; if (i2c_start1 !== 1'b0) begin n_bad++; $display("FAIL timeout_start_low: got %b want 0", i2c_start1); end
        n_cmp++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL timeout_status: got done=%b busy=%b want 0 0", done1, busy1); end
    endtask

    // Test sequence
    initial begin
        rst_n     = 1'b0;
        restart   = 1'b0;
        nack_data = '0;
        nack_left = 0;
        rst1_n    = 1'b0;
        restart1  = 1'b0;
        tbl_data1 = 24'h72_98_03;
        i2c_end1  = 1'b1;
        i2c_ack1  = 1'b0;
        test_reset();
        test_basic();
        test_retry();
        test_error_and_restart();
        test_delay();
        test_restart_mid();
        test_table_end();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_init_seq.md
I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

Interface
REQ-001 Parameter ADDR_W, default 8: table index width; depth is 2**ADDR_W entries.
REQ-002 Parameter RETRIES, default 3: the number of extra attempts made after a NACK before an error is raised.
REQ-003 Parameter DELAY_CYC, default 50_000: clock cycles per delay unit (1 ms at 50 MHz).
REQ-004 Parameter TIMEOUT_CYC, default 2_000_000: maximum cycles to wait for i2c_end before the transfer counts as failed.
REQ-005 iCLK  in  1  system clock; all logic is on the rising edge.
REQ-006 iRST_N  in  1  reset; asynchronous assert, active-low.
REQ-007 restart  in  1  single-cycle pulse that re-runs the table from index 0.
REQ-008 tbl_addr  out  ADDR_W  table read address.
REQ-009 tbl_data  in  24  table entry, valid one cycle after tbl_addr: [23:16] device byte, [15:8] register, [7:0] data.
REQ-010 i2c_data  out  24  {device, register, data} presented to the I2C master.
REQ-011 i2c_start  out  1  transfer request to the master.
REQ-012 i2c_end  in  1  master idle/end flag; low while a transfer is in progress.
REQ-013 i2c_ack  in  1  master ack result, valid when i2c_end is high; 0 = acked, 1 = NACK.
REQ-014 busy  out  1  sequence in progress.
REQ-015 done  out  1  sequence completed without error; sticky.
REQ-016 error  out  1  retries or timeout exhausted; sticky.
REQ-017 err_index  out  ADDR_W  index of the failing entry; 0 when error is low.

Function
REQ-018 The block SHALL use states FETCH, DECODE, START, WAIT_LO, WAIT_HI, DELAY, DONE and ERROR.
REQ-019 FETCH SHALL last exactly one cycle, to cover ROM latency, then go to DECODE.
REQ-020 In DECODE, device byte 8'hFF SHALL mean END and go to DONE.
REQ-021 In DECODE, device byte 8'hFE SHALL mean DELAY and load the delay counter with data*DELAY_CYC; a data value of 0 SHALL skip straight to the next index.
REQ-022 Any other device byte SHALL latch tbl_data into i2c_data, clear the retry count, and go to START.
REQ-023 START SHALL assert i2c_start and go to WAIT_LO.
REQ-024 WAIT_LO SHALL hold i2c_start high until i2c_end is seen low, then go to WAIT_HI.
REQ-025 WAIT_HI SHALL drop i2c_start and wait for i2c_end high, then sample i2c_ack.
REQ-026 On ack=0, the block SHALL advance tbl_addr by 1 and go to FETCH.
REQ-027 On ack=1, if the retry count is below RETRIES, the block SHALL increment the retry count and go to START with the same i2c_data; otherwise it SHALL go to ERROR.
REQ-028 The timeout counter SHALL run through WAIT_LO and WAIT_HI and be cleared on every START; reaching TIMEOUT_CYC SHALL be handled exactly as a NACK.
REQ-029 DELAY SHALL count down to 0 and then advance the index; the count width SHALL hold 255*DELAY_CYC without overflow.
REQ-030 Table end: after the entry at index 2**ADDR_W-1 completes, the block SHALL go to DONE; tbl_addr SHALL never wrap to 0 except through restart or reset.
REQ-031 A restart in DONE or ERROR SHALL clear done, error and err_index, set tbl_addr to 0, and go to FETCH on the next cycle.
REQ-032 A restart in any other state SHALL be latched; an in-flight I2C transfer or delay SHALL finish first, then the restart SHALL apply in place of the next FETCH.
REQ-033 A second restart while one is already latched SHALL have no extra effect.
REQ-034 On entry to ERROR, err_index SHALL be set to the current tbl_addr and error set to 1.
REQ-035 busy SHALL be 1 in every state except DONE and ERROR.
REQ-036 The timing relation between restart and i2c_end SHALL NOT affect the ack decision.

Reset
REQ-037 On iRST_N low, the block SHALL immediately set the state to FETCH, tbl_addr=0, i2c_start=0, i2c_data=0, done=0, error=0, err_index=0, clear all counters, and clear any latched restart.
REQ-038 After reset release, the block SHALL begin the sequence automatically with no restart needed.
REQ-039 Reset mid-transfer SHALL drop i2c_start within the same cycle and abandon the transfer.

Verification
REQ-040 Table {72_98_03, 72_41_10, FF_xx_xx} with master model always acking -> exactly 2 transfers with i2c_data 729803 then 724110; done=1 and busy=0 afterwards.
REQ-041 Entry 72_41_10 NACKed 3 times, then acked, with RETRIES=3 -> 4 transfers of 724110, no error, then done=1.
REQ-042 Entry at index 5 always NACKed, RETRIES=3 -> exactly 4 attempts, then error=1, err_index=5, done=0, and no further i2c_start.
REQ-043 Entry FE_00_02 with DELAY_CYC=10 -> no i2c_start for 20 cycles (±2 for FETCH/DECODE), then the next entry is issued; FE_00_00 -> no delay.
REQ-044 Restart pulsed during the WAIT_HI of index 3 -> the index 3 transfer completes, then tbl_addr=0 and the table replays; restart after ERROR clears error and replays.
REQ-045 i2c_end held high after start, with TIMEOUT_CYC=100 and RETRIES=0 -> error=1 at 100±1 cycles after START; iRST_N pulsed mid-transfer -> i2c_start=0 at once and the sequence restarts at index 0.
